// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encodings and widths for the multiplier sequencer
package mul_pkg;

  localparam int OPW        = 8;
  localparam int PRODW      = 16;
  localparam int MUL_CYCLES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/mul_acc_unit.sv
// rtl/mul_acc_unit.sv - product accumulator with add-enable, group clear and carry-out
module mul_acc_unit
  import mul_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_en,
  input  logic             clr,
  input  logic [PRODW-1:0] addend,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum_ext;

  // Product is zero-extended; the extra top bit is the wrap indication.
  assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PRODW){1'b0}}, addend};
  assign sum     = sum_ext[ACC_W-1:0];
  assign carry   = sum_ext[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/mul_operand_seq.sv
// rtl/mul_operand_seq.sv - streaming front/back end and MAC around the shift-add multiplier
module mul_operand_seq
  import mul_pkg::*;
#(
  parameter int ACC_W    = 24,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic [OPW-1:0]   mul_a,
  output logic [OPW-1:0]   mul_b,
  input  logic [PRODW-1:0] mul_product,
  input  logic             mul_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PRODW-1:0] out_product,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_last,
  output logic             acc_ovf,
  output logic             timeout
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    wait_cnt;
  logic             last_r;
  logic             accept, ready_ok, tmo_hit, capture, release_out, group_clr;
  logic [ACC_W-1:0] acc_sum;
  logic             acc_carry;

  assign accept      = in_valid && in_ready;
  // The first WAIT cycle (wait_cnt==0) may still see the previous op's ready.
  assign ready_ok    = (state == ST_WAIT) && mul_ready && (wait_cnt != '0);
  assign tmo_hit     = (state == ST_WAIT) && !ready_ok && (wait_cnt == CW'(WAIT_MAX - 1));
  assign capture     = ready_ok || tmo_hit;
  assign release_out = (state == ST_OUT) && out_ready;
  assign group_clr   = release_out && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_START;
      end
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (capture) state_nxt = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ST_START) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // mul_start is high during START, i.e. the cycle after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      last_r    <= 1'b0;
    end else begin
      mul_start <= accept;
      if (accept) begin
        mul_a  <= in_a;
        mul_b  <= in_b;
        last_r <= in_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_product <= '0;
      out_acc     <= '0;
      out_last    <= 1'b0;
      acc_ovf     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (capture) begin
        out_product <= mul_product;
        out_acc     <= acc_sum;
        out_last    <= last_r;
      end
      if (group_clr)                acc_ovf <= 1'b0;
      else if (capture && acc_carry) acc_ovf <= 1'b1;
      if (tmo_hit) timeout <= 1'b1;
    end
  end

  mul_acc_unit #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .add_en (capture),
    .clr    (group_clr),
    .addend (mul_product),
    .sum    (acc_sum),
    .carry  (acc_carry)
  );

endmodule

// File: tb/tb_mul_operand_seq.sv
// tb/tb_mul_operand_seq.sv - directed bench for mul_operand_seq with a shift-add multiplier model
module tb_mul_operand_seq;
  import mul_pkg::*;

  localparam int ACC_W    = 16;
  localparam int WAIT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic             in_last = 1'b0;
  logic             mul_start;
  logic [7:0]       mul_a, mul_b;
  logic [15:0]      mul_product = '0;
  logic             mul_ready = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [15:0]      out_product;
  logic [ACC_W-1:0] out_acc;
  logic             out_last;
  logic             acc_ovf;
  logic             timeout;

  mul_operand_seq #(
    .ACC_W    (ACC_W),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_last     (in_last),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_ready   (mul_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_acc     (out_acc),
    .out_last    (out_last),
    .acc_ovf     (acc_ovf),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mul_start) start_hi <= start_hi + 1;

  // Multiplier model: ready rises 8 edges after the edge that samples start.
  // stale_mode keeps the old ready through the first WAIT cycle; hold_mode never raises it.
  logic       stale_mode = 1'b0;
  logic       hold_mode = 1'b0;
  logic       m_busy = 1'b0;
  logic [3:0] m_cnt = '0;
  logic [7:0] m_a = '0, m_b = '0;

  always @(posedge clk) begin
    if (mul_start) begin
      m_busy <= 1'b1;
      m_cnt  <= '0;
      m_a    <= mul_a;
      m_b    <= mul_b;
      if (!stale_mode) mul_ready <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1'b1;
      if (m_cnt == 4'(MUL_CYCLES - 1)) begin
        m_busy <= 1'b0;
        if (!hold_mode) begin
          mul_ready   <= 1'b1;
          mul_product <= m_a * m_b;
        end
      end else begin
        mul_ready <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic last, output int e0);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e0       = cyc;
  endtask

  task automatic wait_out(input int e0, output int lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = cyc - e0;
  endtask

  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic last,
                    input logic [15:0] exp_prod, input logic [15:0] exp_acc, output int e0);
    int lat, s0;
    s0 = start_hi;
    accept(a, b, last, e0);
    wait_out(e0, lat);
    check({tag, ".lat"}, lat, 10);
    check({tag, ".start_cycles"}, start_hi - s0, 1);
    check({tag, ".prod"}, out_product, exp_prod);
    check({tag, ".acc"}, out_acc, exp_acc);
    check({tag, ".last"}, out_last, last);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0, e1, lat, viol;

    repeat (2) @(posedge clk);
    #2;
    check("rst.in_ready", in_ready, 1);
    check("rst.mul_start", mul_start, 0);
    check("rst.mul_a", mul_a, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_acc", out_acc, 0);
    check("rst.flags", {acc_ovf, timeout}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pair
    op("single", 8'd13, 8'd11, 1'b1, 16'd143, 16'd143, e0);
    check("single.mul_a", mul_a, 13);
    check("single.mul_b", mul_b, 11);
    consume();

    // Accumulation with wrap at 16 bits
    op("g1", 8'd255, 8'd255, 1'b0, 16'd65025, 16'd65025, e0);
    check("g1.ovf", acc_ovf, 0);
    consume();
    op("g2", 8'd255, 8'd255, 1'b0, 16'd65025, 16'd64514, e1);
    check("g2.ovf", acc_ovf, 1);
    check("g.interval", e1 - e0, 12);
    consume();
    op("g3", 8'd2, 8'd3, 1'b1, 16'd6, 16'd64520, e0);
    check("g3.ovf_sticky", acc_ovf, 1);
    consume();
    check("g.ovf_cleared", acc_ovf, 0);
    check("g.idle_valid", out_valid, 0);

    // Backpressure, with operand traffic that must be ignored
    out_ready = 1'b0;
    op("bp", 8'd3, 8'd4, 1'b1, 16'd12, 16'd12, e0);
    viol = 0;
    in_valid = 1'b1;
    in_a     = 8'd99;
    in_b     = 8'd98;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!(out_valid && out_product == 16'd12 && out_acc == 16'd12 && !in_ready)) viol++;
    end
    in_valid = 1'b0;
    check("bp.stable", viol, 0);
    check("bp.mul_a_held", mul_a, 3);
    consume();
    check("bp.resume_ready", in_ready, 1);
    check("bp.resume_valid", out_valid, 0);

    // Stale ready from the 3*4 op is still high during the first WAIT cycle
    stale_mode = 1'b1;
    op("stale", 8'd7, 8'd9, 1'b1, 16'd63, 16'd63, e0);
    stale_mode = 1'b0;
    consume();

    // Timeout
    check("pre_tmo.timeout", timeout, 0);
    hold_mode = 1'b1;
    accept(8'd5, 8'd6, 1'b1, e0);
    wait_out(e0, lat);
    check("tmo.lat", lat, 16);
    check("tmo.valid", out_valid, 1);
    check("tmo.timeout", timeout, 1);
    consume();
    hold_mode = 1'b0;
    op("post_tmo", 8'd2, 8'd2, 1'b1, 16'd4, 16'd4, e0);
    check("post_tmo.timeout", timeout, 1);
    consume();

    // Asynchronous reset mid-WAIT with a partial group pending
    op("pre_rst", 8'd10, 8'd10, 1'b0, 16'd100, 16'd100, e0);
    consume();
    accept(8'd1, 8'd1, 1'b1, e0);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.in_ready", in_ready, 1);
    check("arst.mul_a", mul_a, 0);
    check("arst.out_product", out_product, 0);
    check("arst.out_acc", out_acc, 0);
    check("arst.timeout", timeout, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    op("after_rst", 8'd4, 8'd5, 1'b1, 16'd20, 16'd20, e0);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
